// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for the SCC core.
// Fetches an instruction, latches the decoder's class/flag outputs, then steps
// the datapath through EXEC, MEM and WB. Counts retired instructions and
// faults when a memory handshake waits too long for ready.
module core_sequencer #(
  parameter int TIMEOUT = 16,  // cycles a memory request may wait before FAULT (>= 2)
  parameter int CNT_W   = 32   // retired-instruction counter width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             branch,
  input  logic             loadStore,
  input  logic             dataRegister,
  input  logic             dataRegisterImm,
  input  logic             specialEncoding,
  input  logic             setFlags,
  input  logic [2:0]       aluFunction,
  input  logic             branch_taken,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_inc,
  output logic             pc_load,
  output logic [2:0]       alu_op,
  output logic             flags_write,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_write,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6,
    FAULT  = 3'd7
  } stateT;

  // Decoded instruction class; an instruction with no class bit is ILLEGAL
  // and runs like a data op with its side effects suppressed.
  typedef enum logic [1:0] {
    CLS_DATA    = 2'd0,
    CLS_MEM     = 2'd1,
    CLS_BRANCH  = 2'd2,
    CLS_ILLEGAL = 2'd3
  } classT;

  // Wait counter only has to hold 0 .. TIMEOUT-1.
  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  stateT      curState;
  stateT      nextState;
  classT      instrClass;
  logic       isSpecial;
  logic       wantFlags;
  logic [2:0] aluFn;
  logic [TMO_W-1:0] waitCnt;
  logic       waitExpired;
  logic       retire;

  assign state       = curState;
  assign waitExpired = (waitCnt == TMO_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) curState <= IDLE;
    else     curState <= nextState;
  end

  // Capture the decoder's view of the instruction while in DECODE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instrClass <= CLS_DATA;
      isSpecial  <= 1'b0;
      wantFlags  <= 1'b0;
      aluFn      <= 3'b000;
    end else if (curState == DECODE) begin
      if (branch)                               instrClass <= CLS_BRANCH;
      else if (loadStore)                       instrClass <= CLS_MEM;
      else if (dataRegister || dataRegisterImm) instrClass <= CLS_DATA;
      else                                      instrClass <= CLS_ILLEGAL;
      isSpecial <= specialEncoding;
      wantFlags <= setFlags;
      aluFn     <= aluFunction;
    end
  end

  // Handshake wait counter: counts ready=0 cycles in FETCH/MEM, zero elsewhere
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waitCnt <= '0;
    end else if ((curState == FETCH && !imem_ready) ||
                 (curState == MEM   && !dmem_ready)) begin
      waitCnt <= waitCnt + TMO_W'(1);
    end else begin
      waitCnt <= '0;
    end
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         instr_count <= '0;
    else if (retire) instr_count <= instr_count + CNT_W'(1);
  end

  // Next-state and output decode
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    nextState   = curState;
    imem_req    = 1'b0;
    ir_write    = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    alu_op      = 3'b000;
    flags_write = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    reg_write   = 1'b0;
    halted      = 1'b0;
    fault       = 1'b0;

    case (curState)
      IDLE: begin
        if (start) nextState = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        // Ready in the expiring cycle still wins.
        if (imem_ready) begin
          ir_write  = 1'b1;
          pc_inc    = 1'b1;
          nextState = DECODE;
        end else if (waitExpired) begin
          nextState = FAULT;
        end
      end
      DECODE: begin
        nextState = (branch && specialEncoding) ? HALT : EXEC;
      end
      EXEC: begin
        case (instrClass)
          CLS_DATA: begin
            alu_op      = aluFn;
            flags_write = wantFlags;
            nextState   = WB;
          end
          CLS_ILLEGAL: begin
            alu_op    = aluFn;
            nextState = WB;
          end
          CLS_MEM: begin
            nextState = MEM;
          end
          default: begin  // CLS_BRANCH: address add, optional PC load
            pc_load   = branch_taken;
            nextState = FETCH;
          end
        endcase
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = isSpecial;
        if (dmem_ready) begin
          nextState = isSpecial ? FETCH : WB;
        end else if (waitExpired) begin
          nextState = FAULT;
        end
      end
      WB: begin
        reg_write = (instrClass != CLS_ILLEGAL);
        nextState = FETCH;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin  // FAULT
        fault = 1'b1;
      end
    endcase

    retire = (nextState == FETCH) &&
             (curState == EXEC || curState == MEM || curState == WB);
  end

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: randomized self-checking bench for core_sequencer.
// The reference model expands each instruction into the list of states it
// must visit, then checks state, strobes, alu_op and the retire count per cycle.
`timescale 1ns/1ps
module tb_core_sequencer;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 32;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM  = 3'd4, S_WB    = 3'd5, S_HALT   = 3'd6, S_FAULT = 3'd7;

  localparam int K_DATA = 0, K_DIMM = 1, K_LOAD = 2, K_STORE = 3,
                 K_BRANCH = 4, K_ILLEGAL = 5, K_HALT = 6;

  logic clk = 1'b0;
  logic rst, start, imem_ready, dmem_ready;
  logic branch, loadStore, dataRegister, dataRegisterImm, specialEncoding, setFlags;
  logic [2:0] aluFunction;
  logic branch_taken;
  logic imem_req, ir_write, pc_inc, pc_load;
  logic [2:0] alu_op;
  logic flags_write, dmem_req, dmem_we, reg_write, halted, fault;
  logic [2:0] state;
  logic [CNT_W-1:0] instr_count;

  logic [9:0] strobes;
  assign strobes = {imem_req, ir_write, pc_inc, pc_load, flags_write,
                    dmem_req, dmem_we, reg_write, halted, fault};

  int vectors = 0;
  int miscompares = 0;
  logic [CNT_W-1:0] modelCount;

  always #5 clk = ~clk;

  core_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .branch(branch), .loadStore(loadStore), .dataRegister(dataRegister),
    .dataRegisterImm(dataRegisterImm), .specialEncoding(specialEncoding),
    .setFlags(setFlags), .aluFunction(aluFunction), .branch_taken(branch_taken),
    .imem_req(imem_req), .ir_write(ir_write), .pc_inc(pc_inc), .pc_load(pc_load),
    .alu_op(alu_op), .flags_write(flags_write), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .reg_write(reg_write), .halted(halted), .fault(fault),
    .state(state), .instr_count(instr_count)
  );

  // Inputs that should not matter in the current cycle get random values.
  task automatic scrambleInputs();
    start           = 1'($urandom);
    imem_ready      = 1'($urandom);
    dmem_ready      = 1'($urandom);
    branch          = 1'($urandom);
    loadStore       = 1'($urandom);
    dataRegister    = 1'($urandom);
    dataRegisterImm = 1'($urandom);
    specialEncoding = 1'($urandom);
    setFlags        = 1'($urandom);
    aluFunction     = 3'($urandom);
    branch_taken    = 1'($urandom);
  endtask

  // Run one instruction from its first FETCH cycle. A wait of TIMEOUT or more
  // means ready never arrives and the instruction must end in FAULT.
  // abortAfter >= 0 stops after that many cycles with no end-of-instruction check.
  task automatic runInstr(input int kind, input logic [2:0] fn, input logic sf,
                          input logic tk, input int iw, input int dw,
                          input int abortAfter, input string tag);
    logic [2:0] seq[$];
    logic [2:0] endState, st, expAlu;
    logic [9:0] expStrobe;
    logic eIr, isDataCls, isDataLike;
    int nf, nm, fetchIdx, memIdx;
    bit aborted;

    isDataCls  = (kind == K_DATA || kind == K_DIMM);
    isDataLike = isDataCls || kind == K_ILLEGAL;

    nf = (iw >= TIMEOUT) ? TIMEOUT : iw + 1;
    for (int i = 0; i < nf; i++) seq.push_back(S_FETCH);
    endState = S_FETCH;
    if (iw >= TIMEOUT) begin
      endState = S_FAULT;
    end else begin
      seq.push_back(S_DECODE);
      if (kind == K_HALT) begin
        endState = S_HALT;
      end else begin
        seq.push_back(S_EXEC);
        if (kind == K_LOAD || kind == K_STORE) begin
          nm = (dw >= TIMEOUT) ? TIMEOUT : dw + 1;
          for (int i = 0; i < nm; i++) seq.push_back(S_MEM);
          if (dw >= TIMEOUT)       endState = S_FAULT;
          else if (kind == K_LOAD) seq.push_back(S_WB);
        end else if (kind != K_BRANCH) begin
          seq.push_back(S_WB);
        end
      end
    end

    fetchIdx = 0;
    memIdx   = 0;
    aborted  = 1'b0;
    for (int k = 0; k < seq.size(); k++) begin
      if (abortAfter >= 0 && k >= abortAfter) begin
        aborted = 1'b1;
        break;
      end
      st = seq[k];
      scrambleInputs();
      case (st)
        S_FETCH: imem_ready = (fetchIdx == iw);
        S_DECODE: begin
          branch          = (kind == K_BRANCH || kind == K_HALT);
          loadStore       = (kind == K_LOAD || kind == K_STORE);
          dataRegister    = (kind == K_DATA);
          dataRegisterImm = (kind == K_DIMM);
          if (kind == K_STORE || kind == K_HALT)      specialEncoding = 1'b1;
          else if (kind == K_LOAD || kind == K_BRANCH) specialEncoding = 1'b0;
          setFlags    = sf;
          aluFunction = fn;
        end
        S_EXEC: branch_taken = tk;
        S_MEM:  dmem_ready = (memIdx == dw);
        default: ;
      endcase

      eIr       = (st == S_FETCH) && (fetchIdx == iw);
      expStrobe = {st == S_FETCH, eIr, eIr,
                   (st == S_EXEC) && kind == K_BRANCH && tk,
                   (st == S_EXEC) && isDataCls && sf,
                   st == S_MEM,
                   (st == S_MEM) && kind == K_STORE,
                   (st == S_WB) && kind != K_ILLEGAL,
                   1'b0, 1'b0};
      expAlu = (st == S_EXEC && isDataLike) ? fn : 3'b000;

      #1;
      vectors++;
      if (state !== st) begin
        miscompares++;
        $display("FAIL %s cyc%0d state: got %0d want %0d", tag, k, state, st);
      end
      vectors++;
      if (strobes !== expStrobe) begin
        miscompares++;
        $display("FAIL %s cyc%0d strobes: got %b want %b", tag, k, strobes, expStrobe);
      end
      vectors++;
      if (alu_op !== expAlu) begin
        miscompares++;
        $display("FAIL %s cyc%0d alu_op: got %b want %b", tag, k, alu_op, expAlu);
      end
      vectors++;
      if (instr_count !== modelCount) begin
        miscompares++;
        $display("FAIL %s cyc%0d instr_count: got %0d want %0d", tag, k, instr_count, modelCount);
      end
      if (st == S_FETCH) fetchIdx++;
      if (st == S_MEM)   memIdx++;
      @(posedge clk);
      @(negedge clk);
    end

    if (!aborted) begin
      if (endState == S_FETCH) modelCount = modelCount + 1;
      vectors++;
      if (state !== endState) begin
        miscompares++;
        $display("FAIL %s end state: got %0d want %0d", tag, state, endState);
      end
      vectors++;
      if (instr_count !== modelCount) begin
        miscompares++;
        $display("FAIL %s end instr_count: got %0d want %0d", tag, instr_count, modelCount);
      end
    end
  endtask

  // HALT/FAULT must hold with start pulsing and inputs toggling.
  task automatic absorb(input logic [2:0] expState, input int ncyc, input string tag);
    logic [9:0] expStrobe;
    expStrobe = (expState == S_HALT) ? 10'b00000_00010 : 10'b00000_00001;
    for (int i = 0; i < ncyc; i++) begin
      scrambleInputs();
      start = (i % 2 == 0);
      #1;
      vectors++;
      if (state !== expState || strobes !== expStrobe || alu_op !== 3'b000) begin
        miscompares++;
        $display("FAIL %s cyc%0d: got state %0d strobes %b alu %b want state %0d strobes %b alu 000",
                 tag, i, state, strobes, alu_op, expState, expStrobe);
      end
      vectors++;
      if (instr_count !== modelCount) begin
        miscompares++;
        $display("FAIL %s cyc%0d instr_count: got %0d want %0d", tag, i, instr_count, modelCount);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Reset, sit one cycle in IDLE without start, then start; ends in FETCH.
  task automatic restart();
    scrambleInputs();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelCount = '0;
    for (int i = 0; i < 2; i++) begin
      scrambleInputs();
      start = (i == 1);
      #1;
      vectors++;
      if (state !== S_IDLE || strobes !== 10'b0 || alu_op !== 3'b000 || instr_count !== '0) begin
        miscompares++;
        $display("FAIL idle%0d: got state %0d strobes %b alu %b count %0d want 0/0/000/0",
                 i, state, strobes, alu_op, instr_count);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    scrambleInputs();
    #2;
    vectors++;
    if (state !== S_IDLE || strobes !== 10'b0 || alu_op !== 3'b000 || instr_count !== '0) begin
      miscompares++;
      $display("FAIL reset: got state %0d strobes %b alu %b count %0d want 0/0/000/0",
               state, strobes, alu_op, instr_count);
    end
    @(negedge clk);
    restart();
  endtask

  task automatic test_data_op();
    runInstr(K_DATA, 3'b010, 1'b1, 1'b0, 0, 0, -1, "data_op");
    vectors++;
    if (instr_count !== 1) begin
      miscompares++;
      $display("FAIL data_op count: got %0d want 1", instr_count);
    end
  endtask

  task automatic test_load_wait();
    runInstr(K_LOAD, 3'b111, 1'b1, 1'b1, 0, 3, -1, "load_wait");
  endtask

  task automatic test_store_branch();
    restart();
    runInstr(K_STORE, 3'b101, 1'b1, 1'b0, 1, 0, -1, "store");
    runInstr(K_BRANCH, 3'b011, 1'b1, 1'b1, 0, 0, -1, "branch_taken");
    vectors++;
    if (instr_count !== 2) begin
      miscompares++;
      $display("FAIL store_branch count: got %0d want 2", instr_count);
    end
    runInstr(K_BRANCH, 3'b110, 1'b0, 1'b0, 2, 0, -1, "branch_not_taken");
  endtask

  task automatic test_illegal();
    runInstr(K_ILLEGAL, 3'b100, 1'b1, 1'b1, 0, 0, -1, "illegal");
    runInstr(K_DIMM, 3'b001, 1'b1, 1'b0, 0, 0, -1, "data_imm");
  endtask

  task automatic test_timeout_edge();
    runInstr(K_DATA, 3'b011, 1'b0, 1'b0, TIMEOUT - 1, 0, -1, "fetch_ready_last");
    runInstr(K_LOAD, 3'b000, 1'b0, 1'b0, 0, TIMEOUT - 1, -1, "load_ready_last");
    runInstr(K_STORE, 3'b000, 1'b0, 1'b0, 0, TIMEOUT - 1, -1, "store_ready_last");
  endtask

  task automatic test_random();
    int kind, iw, dw;
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 5);
      iw   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TIMEOUT - 1) : $urandom_range(0, 2);
      dw   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TIMEOUT - 1) : $urandom_range(0, 2);
      runInstr(kind, 3'($urandom), 1'($urandom), 1'($urandom), iw, dw, -1, "random");
    end
  endtask

  task automatic test_reset_mid();
    runInstr(K_STORE, 3'b000, 1'b0, 1'b0, 0, 5, 5, "store_abort");
    vectors++;
    if (state !== S_MEM || modelCount == '0) begin
      miscompares++;
      $display("FAIL reset_mid setup: got state %0d count %0d want 4 and nonzero", state, instr_count);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (state !== S_IDLE || strobes !== 10'b0 || instr_count !== '0 || fault !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got state %0d strobes %b count %0d fault %b want 0/0/0/0",
               state, strobes, instr_count, fault);
    end
    @(negedge clk);
  endtask

  task automatic test_halt();
    restart();
    runInstr(K_DATA, 3'b110, 1'b1, 1'b0, 0, 0, -1, "pre_halt");
    runInstr(K_HALT, 3'b010, 1'b0, 1'b1, 0, 0, -1, "halt");
    absorb(S_HALT, 10, "halt_hold");
  endtask

  task automatic test_fault_fetch();
    restart();
    runInstr(K_DATA, 3'b001, 1'b0, 1'b0, TIMEOUT, 0, -1, "fetch_timeout");
    absorb(S_FAULT, 8, "fault_hold");
  endtask

  task automatic test_fault_mem();
    restart();
    runInstr(K_BRANCH, 3'b001, 1'b0, 1'b1, 0, 0, -1, "pre_fault");
    runInstr(K_LOAD, 3'b001, 1'b0, 1'b0, 0, TIMEOUT + 3, -1, "mem_timeout");
    absorb(S_FAULT, 6, "mem_fault_hold");
  endtask

  initial begin
    modelCount = '0;
    test_reset();
    test_data_op();
    test_load_wait();
    test_store_branch();
    test_illegal();
    test_timeout_edge();
    test_random();
    test_reset_mid();
    test_halt();
    test_fault_fetch();
    test_fault_mem();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM that sequences the SCC core around the instruction decoder. It fetches an instruction and latches the decoder's class and flag outputs. It then steps the datapath through execute, memory and writeback, driving register-file, ALU, flag, PC and memory strobes. It also counts retired instructions and faults on memory handshake timeouts.

## Interface
- `TIMEOUT`, 16: cycles a memory request may wait for ready before FAULT (≥2).
- `CNT_W`, 32: width of retired-instruction counter.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  leave IDLE and begin fetching.
- `imem_ready`  in  1  instruction memory has word on bus; IR may capture.
- `dmem_ready`  in  1  data memory access complete.
- `branch`, `loadStore`, `dataRegister`, `dataRegisterImm`  in  1 each  one-hot class from decoder.
- `specialEncoding`  in  1  loadStore class: 1=store, 0=load; branch class: 1=HALT.
- `setFlags`  in  1  data instruction updates flags.
- `aluFunction`  in  3  ALU op from decoder.
- `branch_taken`  in  1  condition unit result, valid in EXEC.
- `imem_req`, `ir_write`, `pc_inc`, `pc_load`  out  1 each  fetch/PC strobes.
- `alu_op`  out  3  ALU operation.
- `flags_write`, `dmem_req`, `dmem_we`, `reg_write`  out  1 each.
- `halted`, `fault`  out  1 each  sticky status.
- `state`  out  3  current state encoding.
- `instr_count`  out  CNT_W  retired instructions.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
- IDLE: start=1 → FETCH.
- FETCH: imem_req=1. imem_ready=1 → ir_write=1, pc_inc=1 that cycle, → DECODE.
- DECODE: latch class, specialEncoding, setFlags, aluFunction into internal regs. Branch with specialEncoding=1 → HALT; else → EXEC.
- EXEC: alu_op = latched aluFunction for data classes, 3'b000 (ADD) for load/store/branch.
  - flags_write=1 if data class and setFlags.
  - Branch: pc_load=branch_taken, → FETCH.
  - Load/store → MEM.
  - Data → WB.
- MEM: dmem_req=1; dmem_we=1 for store. On dmem_ready: load → WB; store → FETCH.
- WB: reg_write=1 → FETCH.
- HALT: halted=1. FAULT: fault=1. Both absorbing until rst; start ignored.
- Retire: instr_count +1 on every transition into FETCH from EXEC, MEM or WB. HALT is not counted. Wraps modulo 2^CNT_W.
- Timeout counter:
  - Cleared on entry to FETCH or MEM; increments each cycle in FETCH/MEM with ready=0.
  - Ready=0 while counter = TIMEOUT−1 → FAULT, so FAULT is entered after TIMEOUT waiting cycles.
  - Ready=1 in that same cycle wins and proceeds normally.
- Decoder inputs matter only in DECODE (and branch_taken in EXEC); other cycles ignore them.
- No class bit set in DECODE (illegal): treated as data-register, → EXEC with no flags_write, then WB with reg_write suppressed.

## Timing
- Reset (async, immediate): state=IDLE, instr_count=0, counters and latches 0, all strobes 0, halted=0, fault=0.
- All outputs are Moore-decoded from state and latched regs. Exceptions: ir_write/pc_inc also need imem_ready, and pc_load needs branch_taken (Mealy, same cycle).
- Latency from FETCH entry to next FETCH entry, ready asserted immediately:
  - Branch: 3 cycles.
  - Data: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each wait cycle adds 1.
- rst mid-instruction: abort; no strobe in the reset cycle; return to IDLE.

## Test plan
- Reset then start=1, data-reg op aluFunction=3'b010, setFlags=1, readies high → states 1,2,3,5,1; alu_op=010 and flags_write=1 in EXEC; reg_write=1 in WB; instr_count=1.
- Load, dmem_ready delayed 3 cycles → MEM held 4 cycles with dmem_req=1 and dmem_we=0; then WB with reg_write=1; count increments once.
- Store then taken branch (branch_taken=1) → dmem_we=1 in MEM, no reg_write; pc_load=1 in EXEC of branch; count=2 after both.
- Branch with specialEncoding=1 → DECODE→HALT; halted=1; start pulses ignored; count unchanged.
- imem_ready held 0, TIMEOUT=16 → FAULT after exactly 16 FETCH cycles. Repeat with ready=1 on the 16th cycle → DECODE, no fault.
- rst asserted in MEM mid-store → immediate IDLE, dmem_req=0, instr_count=0, fault=0.
